// File: rtl/shreg_ctrl.sv
// Command sequencer for the structural universal shift register: turns one load/shift/rotate
// command at a time into a settle cycle followed by a burst of flop-enable cycles.
module shreg_ctrl #(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic             CMD_DIR,
    input  logic [CNT_W-1:0] CMD_LEN,
    input  logic [N-1:0]     CMD_DATA,
    input  logic             CMD_SIN,
    output logic             ENB,
    output logic             DIR,
    output logic             MODO1,
    output logic             MODO0,
    output logic [N-1:0]     D,
    output logic             S_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] REMAIN
);

    typedef enum logic [1:0] {StIdle, StSetup, StRun, StFin} state_e;

    localparam logic [1:0] OpLoad  = 2'b00;
    localparam logic [1:0] OpShift = 2'b01;
    localparam logic [1:0] OpRot   = 2'b10;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic             enb_q, enb_d;
    logic             dir_q, dir_d;
    logic             modo1_q, modo1_d;
    logic             modo0_q, modo0_d;
    logic [N-1:0]     d_q, d_d;
    logic             s_in_q, s_in_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        len_d    = len_q;
        remain_d = remain_q;
        enb_d    = 1'b0;
        dir_d    = dir_q;
        modo1_d  = modo1_q;
        modo0_d  = modo0_q;
        d_d      = d_q;
        s_in_d   = s_in_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (CMD_VALID) begin
                    op_d    = CMD_OP;
                    len_d   = CMD_LEN;
                    state_d = StSetup;
                    // Selects move here so the mux chain settles during StSetup.
                    case (CMD_OP)
                        OpLoad: begin
                            modo1_d = 1'b1;
                            d_d     = CMD_DATA;
                        end
                        OpShift: begin
                            modo1_d = 1'b0;
                            modo0_d = 1'b0;
                            dir_d   = CMD_DIR;
                            s_in_d  = CMD_SIN;
                        end
                        OpRot: begin
                            modo1_d = 1'b0;
                            modo0_d = 1'b1;
                            dir_d   = CMD_DIR;
                        end
                        default: ;
                    endcase
                end
            end
            StSetup: begin
                if (op_q == OpLoad) begin
                    state_d  = StRun;
                    enb_d    = 1'b1;
                    remain_d = '0;
                end else if ((op_q == OpShift || op_q == OpRot) && len_q != '0) begin
                    state_d  = StRun;
                    enb_d    = 1'b1;
                    remain_d = len_q - CNT_W'(1);
                end else begin
                    state_d = StFin;
                    done_d  = 1'b1;
                end
            end
            StRun: begin
                if (remain_q == '0) begin
                    state_d = StFin;
                    done_d  = 1'b1;
                end else begin
                    enb_d    = 1'b1;
                    remain_d = remain_q - CNT_W'(1);
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= StIdle;
            op_q     <= '0;
            len_q    <= '0;
            remain_q <= '0;
            enb_q    <= 1'b0;
            dir_q    <= 1'b0;
            modo1_q  <= 1'b0;
            modo0_q  <= 1'b0;
            d_q      <= '0;
            s_in_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            len_q    <= len_d;
            remain_q <= remain_d;
            enb_q    <= enb_d;
            dir_q    <= dir_d;
            modo1_q  <= modo1_d;
            modo0_q  <= modo0_d;
            d_q      <= d_d;
            s_in_q   <= s_in_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign CMD_READY = (state_q == StIdle) && !RESET;
    assign ENB       = enb_q;
    assign DIR       = dir_q;
    assign MODO1     = modo1_q;
    assign MODO0     = modo0_q;
    assign D         = d_q;
    assign S_IN      = s_in_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign REMAIN    = remain_q;

endmodule
